seq_endpoint_tracker: RTL and testbench

- Synthesizable, multi-channel sequence end-point detector with cross-domain hold.
- Each channel recognises a programmable sequence of up to DEPTH consecutive step conditions, sampled on a source tick, with overlapping attempts.
- Produces a one-cycle "ended" pulse per detected end point, plus a "matched" indication held until the next destination tick.
- Serves as the RTL reference model and scoreboard aid for ended/matched checking in the assertion benches; both tick domains are emulated as enables on one clock.

---
 rtl/seq_endpoint_tracker.sv | 109 ++++++++++
 tb/tb_seq_endpoint_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_endpoint_tracker.sv
// Multi-channel sequence end-point detector: each channel chains up to DEPTH step
// conditions on src_tick and holds every detected end point until a dst_tick consumes it.
module seq_endpoint_tracker #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src_tick,
  input  logic                    dst_tick,
  input  logic                    flush_i,
  input  logic [LEN_W-1:0]        seq_len,
  input  logic [N_CH*DEPTH-1:0]   step_i,
  output logic [N_CH-1:0]         ended_o,
  output logic [N_CH-1:0]         matched_o,
  output logic [N_CH-1:0]         pending_o,
  output logic [N_CH*CNT_W-1:0]   drop_cnt_o
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] effLen;
  logic             clearAct;
  logic [DEPTH-1:0] lenMask;

  logic [DEPTH-1:0] act_q [N_CH];
  logic [DEPTH-1:0] act_d [N_CH];
  logic [DEPTH-1:0] chain [N_CH];
  logic [CNT_W-1:0] drop_q [N_CH];
  logic [CNT_W-1:0] drop_d [N_CH];

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] consume;
  logic [N_CH-1:0] pend_q;
  logic [N_CH-1:0] pend_d;
  logic [N_CH-1:0] ended_q;
  logic [N_CH-1:0] matched_q;

  // A seq_len change discards in-flight attempts exactly like a flush, but keeps pend.
  always_comb begin
    effLen   = (int'(seq_len) > DEPTH) ? LEN_W'(DEPTH) : seq_len;
    clearAct = flush_i | (seq_len != len_q);
    for (int k = 0; k < DEPTH; k++) begin
      lenMask[k] = (k < int'(effLen));
    end
  end

  // chain[k] is "steps 0..k all true ending now"; its bit L-1 is the hit for length L.
  always_comb begin
    for (int ch = 0; ch < N_CH; ch++) begin
      chain[ch] = DEPTH'({act_q[ch], 1'b1}) & step_i[ch*DEPTH +: DEPTH];
      hit[ch]   = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (int'(effLen) == k + 1) begin
          hit[ch] = chain[ch][k];
        end
      end
      hit[ch] = hit[ch] & src_tick & ~clearAct;

      act_d[ch] = act_q[ch];
      if (clearAct) begin
        act_d[ch] = '0;
      end else if (src_tick) begin
        act_d[ch] = chain[ch] & lenMask;
      end

      // Only an end point already held at the start of the cycle can be consumed.
      consume[ch] = dst_tick & pend_q[ch] & ~flush_i;
      pend_d[ch]  = ~flush_i & (hit[ch] | (pend_q[ch] & ~consume[ch]));

      drop_d[ch] = drop_q[ch];
      if (hit[ch] && pend_q[ch] && !consume[ch] && (drop_q[ch] != {CNT_W{1'b1}})) begin
        drop_d[ch] = drop_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      pend_q    <= '0;
      ended_q   <= '0;
      matched_q <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        act_q[ch]  <= '0;
        drop_q[ch] <= '0;
      end
    end else begin
      len_q     <= seq_len;
      pend_q    <= pend_d;
      ended_q   <= hit;
      matched_q <= consume;
      for (int ch = 0; ch < N_CH; ch++) begin
        act_q[ch]  <= act_d[ch];
        drop_q[ch] <= drop_d[ch];
      end
    end
  end

  assign ended_o   = ended_q;
  assign matched_o = matched_q;
  assign pending_o = pend_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : gDropOut
    assign drop_cnt_o[ch*CNT_W +: CNT_W] = drop_q[ch];
  end

endmodule

// File: tb/tb_seq_endpoint_tracker.sv
// Randomized and directed bench for seq_endpoint_tracker; the reference model matches
// each step against a sliding window of past source-tick samples.
module tb_seq_endpoint_tracker;
  localparam int N_CH  = 2;
  localparam int DEPTH = 4;
  localparam int LEN_W = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, srcTick, dstTick, flush;
  logic [LEN_W-1:0]      seqLen;
  logic [N_CH*DEPTH-1:0] steps;
  logic [N_CH-1:0]       endedO, matchedO, pendingO;
  logic [N_CH*CNT_W-1:0] dropCnt;
  logic [N_CH-1:0]       satEnded, satMatched, satPending;
  logic [N_CH*2-1:0]     satDrop;
  logic [31:0]           gotVec;

  seq_endpoint_tracker #(.N_CH(N_CH), .DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src_tick(srcTick), .dst_tick(dstTick), .flush_i(flush),
    .seq_len(seqLen), .step_i(steps), .ended_o(endedO), .matched_o(matchedO),
    .pending_o(pendingO), .drop_cnt_o(dropCnt)
  );

  // Narrow-counter instance shares all inputs and exercises saturation.
  seq_endpoint_tracker #(.N_CH(N_CH), .DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .src_tick(srcTick), .dst_tick(dstTick), .flush_i(flush),
    .seq_len(seqLen), .step_i(steps), .ended_o(satEnded), .matched_o(satMatched),
    .pending_o(satPending), .drop_cnt_o(satDrop)
  );

  assign gotVec = {endedO, matchedO, pendingO, dropCnt, satEnded, satMatched, satPending, satDrop};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N_CH-1:0]  mEnded, mMatched, mPend;
  int               mDrop [N_CH];
  logic [DEPTH-1:0] mHist [N_CH][DEPTH];
  int               mHistCnt [N_CH];
  logic [LEN_W-1:0] mPrevLen;

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  function automatic logic [31:0] expVec();
    return {mEnded, mMatched, mPend, sat8(mDrop[1]), sat8(mDrop[0]),
            mEnded, mMatched, mPend, sat2(mDrop[1]), sat2(mDrop[0])};
  endfunction

  // Hit = the last L source samples (current one included) carry steps 0..L-1 in order.
  task automatic model_step(input logic r, s, d, f, input logic [LEN_W-1:0] len,
                            input logic [N_CH*DEPTH-1:0] st);
    int  L;
    bit  chg, win, hitB, consB;
    if (r) begin
      mEnded = '0; mMatched = '0; mPend = '0; mPrevLen = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        mDrop[ch] = 0; mHistCnt[ch] = 0;
      end
      return;
    end
    L   = (int'(len) > DEPTH) ? DEPTH : int'(len);
    chg = (len != mPrevLen);
    for (int ch = 0; ch < N_CH; ch++) begin
      win = 1'b1;
      if (L == 0 || mHistCnt[ch] < L - 1) begin
        win = 1'b0;
      end else begin
        if (!st[ch*DEPTH + L - 1]) win = 1'b0;
        for (int b = 1; b < L; b++) begin
          if (!mHist[ch][b-1][L-1-b]) win = 1'b0;
        end
      end
      hitB  = s && !f && !chg && win;
      consB = d && mPend[ch] && !f;
      mEnded[ch]   = hitB;
      mMatched[ch] = consB;
      if (hitB && mPend[ch] && !consB) mDrop[ch]++;
      mPend[ch] = !f && (hitB || (mPend[ch] && !consB));
      if (f || chg) begin
        mHistCnt[ch] = 0;
      end else if (s) begin
        for (int j = DEPTH - 1; j > 0; j--) mHist[ch][j] = mHist[ch][j-1];
        mHist[ch][0] = st[ch*DEPTH +: DEPTH];
        if (mHistCnt[ch] < DEPTH) mHistCnt[ch]++;
      end
    end
    mPrevLen = len;
  endtask

  task automatic drive(input logic r, s, d, f, input logic [LEN_W-1:0] len,
                       input logic [N_CH*DEPTH-1:0] st);
    rst = r; srcTick = s; dstTick = d; flush = f; seqLen = len; steps = st;
    model_step(r, s, d, f, len, st);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 3'd2, 8'hFF);
      total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL reset_model cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
    end
    total++; if (gotVec !== 32'h0) begin bad++; $display("[TB] FAIL reset_zero got=%h exp=0", gotVec); end
  endtask

  task automatic test_base_endpoint();
    logic [7:0] st [4] = '{8'h00, 8'h01, 8'h02, 8'h00};
    logic [1:0] s  [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    drive(1, 0, 0, 0, 3'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(0, s[i][0], 0, 0, 3'd2, st[i]);
      total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL base_model cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
      if (i == 2) begin
        total++; if (endedO !== 2'b01 || pendingO !== 2'b01) begin bad++; $display("[TB] FAIL base_ended got=%b/%b exp=01/01", endedO, pendingO); end
      end
    end
    total++; if (endedO !== 2'b00 || pendingO !== 2'b01) begin bad++; $display("[TB] FAIL base_after got=%b/%b exp=00/01", endedO, pendingO); end
  endtask

  task automatic test_overlap();
    drive(1, 0, 0, 0, 3'd3, 8'h00);
    drive(0, 0, 0, 0, 3'd3, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 0, 0, 3'd3, 8'h0F);
      total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL overlap_model cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
      total++; if (endedO[0] !== (i >= 3)) begin bad++; $display("[TB] FAIL overlap_pulse tick=%0d got=%b exp=%b", i, endedO[0], i >= 3); end
    end
    total++; if (dropCnt[7:0] !== 8'd2) begin bad++; $display("[TB] FAIL overlap_drop got=%0d exp=2", dropCnt[7:0]); end
  endtask

  task automatic test_hold();
    drive(1, 0, 0, 0, 3'd1, 8'h00);
    drive(0, 0, 0, 0, 3'd1, 8'h00);
    drive(0, 1, 1, 0, 3'd1, 8'h01);
    total++; if (matchedO !== 2'b00 || pendingO !== 2'b01) begin bad++; $display("[TB] FAIL hold_same got=%b/%b exp=00/01", matchedO, pendingO); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, (i == 3), 0, 3'd1, 8'h00);
      total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL hold_model cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
    end
    total++; if (matchedO !== 2'b01 || pendingO !== 2'b00) begin bad++; $display("[TB] FAIL hold_consume got=%b/%b exp=01/00", matchedO, pendingO); end
  endtask

  task automatic test_reset_flush_mid();
    drive(1, 0, 0, 0, 3'd4, 8'h00);
    drive(0, 0, 0, 0, 3'd4, 8'h00);
    drive(0, 1, 0, 0, 3'd4, 8'h01);
    drive(0, 1, 0, 0, 3'd4, 8'h02);
    drive(1, 0, 0, 0, 3'd4, 8'h00);
    drive(0, 1, 0, 0, 3'd4, 8'h04);
    drive(0, 1, 0, 0, 3'd4, 8'h08);
    total++; if (gotVec !== 32'h0 || gotVec !== expVec()) begin bad++; $display("[TB] FAIL rst_mid got=%h exp=0", gotVec); end
    // Build one drop with length 1, then abort a length-4 attempt via flush.
    drive(0, 0, 0, 0, 3'd1, 8'h00);
    drive(0, 1, 0, 0, 3'd1, 8'h01);
    drive(0, 1, 0, 0, 3'd1, 8'h01);
    drive(0, 0, 0, 0, 3'd4, 8'h00);
    drive(0, 1, 0, 0, 3'd4, 8'h01);
    drive(0, 1, 0, 0, 3'd4, 8'h02);
    drive(0, 0, 1, 1, 3'd4, 8'h00);
    total++; if (matchedO !== 2'b00 || pendingO !== 2'b00) begin bad++; $display("[TB] FAIL flush_clear got=%b/%b exp=00/00", matchedO, pendingO); end
    drive(0, 1, 0, 0, 3'd4, 8'h04);
    drive(0, 1, 0, 0, 3'd4, 8'h08);
    total++; if (endedO !== 2'b00 || dropCnt !== 16'h0001) begin bad++; $display("[TB] FAIL flush_mid got=%b/%h exp=00/0001", endedO, dropCnt); end
    total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL flush_model cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
  endtask

  task automatic test_length();
    drive(1, 0, 0, 0, 3'd7, 8'h00);
    drive(0, 0, 0, 0, 3'd7, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 0, 3'd7, 8'h0F);
      total++; if (endedO[0] !== (i == 4) || gotVec !== expVec()) begin bad++; $display("[TB] FAIL clamp tick=%0d got=%h exp=%h", i, gotVec, expVec()); end
    end
    drive(0, 0, 0, 1, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 3'd0, 8'hFF);
      total++; if (endedO !== 2'b00 || gotVec !== expVec()) begin bad++; $display("[TB] FAIL len0 cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
    end
    drive(0, 0, 0, 0, 3'd3, 8'h00);
    drive(0, 1, 0, 0, 3'd3, 8'h11);
    drive(0, 0, 0, 0, 3'd2, 8'h00);
    drive(0, 1, 0, 0, 3'd2, 8'h22);
    total++; if (endedO !== 2'b00 || gotVec !== expVec()) begin bad++; $display("[TB] FAIL len_change got=%h exp=%h", gotVec, expVec()); end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 3'd1, 8'h00);
    drive(0, 0, 0, 0, 3'd1, 8'h00);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 3'd1, 8'h01);
    total++; if (satDrop[1:0] !== 2'd3 || dropCnt[7:0] !== 8'd5) begin bad++; $display("[TB] FAIL saturation got=%0d/%0d exp=3/5", satDrop[1:0], dropCnt[7:0]); end
    total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL sat_model got=%h exp=%h", gotVec, expVec()); end
  endtask

  task automatic test_random();
    logic [LEN_W-1:0] len;
    logic r, f, s, d;
    len = 3'd2;
    drive(1, 0, 0, 0, len, 8'h00);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(63) == 0);
      f = ($urandom_range(15) == 0);
      if ($urandom_range(19) == 0) len = 3'($urandom_range(7));
      s = 1'($urandom_range(1));
      d = ($urandom_range(9) < 3);
      drive(r, s, d, f, len, 8'($urandom | $urandom));
      total++; if (gotVec !== expVec()) begin bad++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, gotVec, expVec()); end
    end
  endtask

  initial begin
    rst = 1'b1; srcTick = 1'b0; dstTick = 1'b0; flush = 1'b0; seqLen = '0; steps = '0;
    test_reset();
    test_base_endpoint();
    test_overlap();
    test_hold();
    test_reset_flush_mid();
    test_length();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
